// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared types and constants for the MIPS fetch stage: fetch FSM
//               state encoding, redirect-select encoding, reset PC and the
//               bubble instruction word.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  // Reset PC: start of the MIPS user text segment
  localparam logic [31:0] c_PC_RESET = 32'h0040_0000;

  // Bubble word placed in IF/ID when the slot is flushed or empty (sll $0,$0,0)
  localparam logic [31:0] c_NOP_WORD = 32'h0000_0000;

  // Fetch FSM states
  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request outstanding
    HOLD  = 2'd1,  // word captured during a stall, waiting to enter IF/ID
    DRAIN = 2'd2   // request abandoned by a redirect, late word to be dropped
  } fetchState_t;

  // Next-PC redirect source selected from ID
  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_BR   = 2'd1,
    RD_J    = 2'd2,
    RD_JR   = 2'd3
  } redirectSel_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/instruction_fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_stage_if
// Description : Instruction-memory request/response bundle between the fetch
//               stage (master) and the instruction memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_fetch_stage_if;

  logic        IMemReq_o;    // fetch request
  logic [31:0] IMemAddr_o;   // fetch address (current PC)
  logic        IMemValid_i;  // instruction word valid this cycle
  logic [31:0] IMemInstr_i;  // returned instruction word

  modport master (
    output IMemReq_o,
    output IMemAddr_o,
    input  IMemValid_i,
    input  IMemInstr_i
  );

  modport slave (
    input  IMemReq_o,
    input  IMemAddr_o,
    output IMemValid_i,
    output IMemInstr_i
  );

endinterface : instruction_fetch_stage_if
`default_nettype wire

// File: rtl/if_id_register.sv
`default_nettype none
// ============================================================================
// Module      : if_id_register
// Description : IF/ID pipeline register holding instruction, PC, PC+4 and a
//               valid flag. Flush inserts a bubble and has priority over load;
//               with neither asserted the register holds its contents.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_register
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = c_NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,      // asynchronous, active-low
  input  logic        i_load,
  input  logic        i_flush,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_pcPlus4,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pcPlus4,
  output logic        o_valid
);

  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [31:0] r_pcPlus4;
  logic        r_valid;

  // Pipeline register: bubble on flush, capture on load, otherwise hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr   <= NOP_WORD;
      r_pc      <= 32'h0;
      r_pcPlus4 <= 32'h0;
      r_valid   <= 1'b0;
    end else if (i_flush) begin
      r_instr   <= NOP_WORD;
      r_valid   <= 1'b0;
    end else if (i_load) begin
      r_instr   <= i_instr;
      r_pc      <= i_pc;
      r_pcPlus4 <= i_pcPlus4;
      r_valid   <= 1'b1;
    end
  end

  assign o_instr   = r_instr;
  assign o_pc      = r_pc;
  assign o_pcPlus4 = r_pcPlus4;
  assign o_valid   = r_valid;

endmodule : if_id_register
`default_nettype wire

// File: rtl/instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_stage
// Description : MIPS instruction fetch stage. Owns the PC, issues requests to a
//               variable-latency instruction memory, absorbs hazard stalls via
//               a one-word holding register, and applies JR/J/branch redirects
//               from ID by flushing IF/ID and draining abandoned requests.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET = c_PC_RESET,
  parameter logic [31:0] NOP_WORD = c_NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,          // asynchronous, active-low
  input  logic        Stall_i,
  input  logic        BranchTaken_i,
  input  logic [31:0] BranchTarget_i,
  input  logic        J_i,
  input  logic [25:0] JTarget_i,
  input  logic        JR_i,
  input  logic [31:0] RegRs_i,
  instruction_fetch_stage_if.master imem,
  output logic [31:0] Instr_o,
  output logic [31:0] PC_o,
  output logic [31:0] PCPlus4_o,
  output logic        Valid_o
);

  fetchState_t  r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_holdInstr;
  logic         r_imemReq;

  redirectSel_t w_redirSel;
  logic         w_redirect;
  logic [31:0]  w_target;
  logic [31:0]  w_pcPlus4;
  logic         w_fetchLoad;
  logic         w_holdLoad;
  logic         w_ifidLoad;
  logic         w_ifidFlush;
  logic [31:0]  w_ifidInstr;

  assign w_pcPlus4 = r_pc + 32'd4;

  // Redirect source: only a real, unstalled instruction in ID may redirect
  always_comb begin
    w_redirSel = RD_NONE;
    if (Valid_o && !Stall_i) begin
      if (JR_i)               w_redirSel = RD_JR;
      else if (J_i)           w_redirSel = RD_J;
      else if (BranchTaken_i) w_redirSel = RD_BR;
    end
  end

  assign w_redirect = (w_redirSel != RD_NONE);

  // Redirect target; JR masks the low bits so fetches stay word-aligned
  always_comb begin
    w_target = w_pcPlus4;
    case (w_redirSel)
      RD_JR:   w_target = RegRs_i & 32'hFFFF_FFFC;
      RD_J:    w_target = {PCPlus4_o[31:28], JTarget_i, 2'b00};
      RD_BR:   w_target = BranchTarget_i;
      default: w_target = w_pcPlus4;
    endcase
  end

  // r_imemReq is only high in FETCH, so a qualified response implies FETCH
  assign w_fetchLoad = r_imemReq & imem.IMemValid_i & ~Stall_i & ~w_redirect;
  assign w_holdLoad  = (r_state == HOLD) & ~Stall_i & ~w_redirect;
  assign w_ifidLoad  = w_fetchLoad | w_holdLoad;
  // Any unstalled cycle that does not deliver a word advances a bubble into
  // ID; this also covers the flush on redirect
  assign w_ifidFlush = ~Stall_i & ~w_ifidLoad;
  assign w_ifidInstr = (r_state == HOLD) ? r_holdInstr : imem.IMemInstr_i;

  // Fetch FSM with PC, holding register and registered request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= FETCH;
      r_pc        <= PC_RESET;
      r_holdInstr <= NOP_WORD;
      r_imemReq   <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (w_redirect) begin
            r_pc        <= w_target;
            r_holdInstr <= NOP_WORD;
            if (imem.IMemValid_i) begin
              r_state   <= FETCH;
              r_imemReq <= 1'b1;
            end else begin
              r_state   <= DRAIN;
              r_imemReq <= 1'b0;
            end
          end else if (r_imemReq && imem.IMemValid_i) begin
            if (Stall_i) begin
              r_holdInstr <= imem.IMemInstr_i;
              r_state     <= HOLD;
              r_imemReq   <= 1'b0;
            end else begin
              r_pc      <= w_pcPlus4;
              r_state   <= FETCH;
              r_imemReq <= 1'b1;
            end
          end else begin
            r_state   <= FETCH;
            r_imemReq <= 1'b1;
          end
        end
        HOLD: begin
          if (w_redirect) begin
            r_pc        <= w_target;
            r_holdInstr <= NOP_WORD;
            r_state     <= FETCH;
            r_imemReq   <= 1'b1;
          end else if (!Stall_i) begin
            r_pc        <= w_pcPlus4;
            r_holdInstr <= NOP_WORD;
            r_state     <= FETCH;
            r_imemReq   <= 1'b1;
          end else begin
            r_state   <= HOLD;
            r_imemReq <= 1'b0;
          end
        end
        DRAIN: begin
          if (imem.IMemValid_i) begin
            r_state   <= FETCH;
            r_imemReq <= 1'b1;
          end else begin
            r_state   <= DRAIN;
            r_imemReq <= 1'b0;
          end
        end
        default: begin
          r_state   <= FETCH;
          r_imemReq <= 1'b0;
        end
      endcase
    end
  end

  assign imem.IMemReq_o  = r_imemReq;
  assign imem.IMemAddr_o = r_pc;

  if_id_register #(
    .NOP_WORD (NOP_WORD)
  ) u_ifId (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_ifidLoad),
    .i_flush   (w_ifidFlush),
    .i_instr   (w_ifidInstr),
    .i_pc      (r_pc),
    .i_pcPlus4 (w_pcPlus4),
    .o_instr   (Instr_o),
    .o_pc      (PC_o),
    .o_pcPlus4 (PCPlus4_o),
    .o_valid   (Valid_o)
  );

endmodule : instruction_fetch_stage
`default_nettype wire
